// File: rtl/prng_lfsr_core.sv
// Galois LFSR word generator with a small output FIFO, seeded and stepped by register strobes.
// Optional macro PRNG_ZERO_SEED_GUARD_EN: a zero seed loads 1 instead and sets sticky seed_err.
//
// state    | meaning
// ST_IDLE  | no generation
// ST_FREE  | push one word per cycle while the FIFO has room (or is being popped)
// ST_BURST | push until the remaining count reaches 0; stalls on a full FIFO
module prng_lfsr_core #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] TAPS       = 32'h80200003,
    parameter int                    FIFO_DEPTH = 4,
    localparam int                   PW         = $clog2(FIFO_DEPTH),
    localparam int                   LW         = PW + 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] seed_data,
    input  logic                  seed_we,
    input  logic                  enable,
    input  logic [7:0]            burst_len,
    input  logic                  burst_start,
    input  logic                  rd_pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [LW-1:0]         fifo_level,
    output logic                  busy,
    output logic                  seed_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FREE  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [8:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] s_q, s_d;
    logic [DATA_WIDTH-1:0] s_step;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  push_en;
    logic                  pop_en;

    assign s_step  = {1'b0, s_q[DATA_WIDTH-1:1]} ^ (s_q[0] ? TAPS : '0);
    assign pop_en  = rd_pop && (level_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts a push.
    assign push_en = (state_q != ST_IDLE) && !seed_we
                     && ((level_q < LW'(FIFO_DEPTH)) || rd_pop);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!seed_we) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d = ST_FREE;
                    end else if (burst_start) begin
                        state_d = ST_BURST;
                        cnt_d   = (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
                    end
                end
                ST_FREE: begin
                    if (!enable) state_d = ST_IDLE;
                end
                ST_BURST: begin
                    if (push_en) begin
                        cnt_d = cnt_q - 9'd1;
                        if (cnt_q == 9'd1) state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    always_comb begin
        s_d = s_q;
        if (seed_we) begin
`ifdef PRNG_ZERO_SEED_GUARD_EN
            s_d = (seed_data == '0) ? DATA_WIDTH'(1) : seed_data;
`else
            s_d = seed_data;
`endif
        end else if (push_en) begin
            s_d = s_step;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_en && !pop_en)      level_d = level_q + LW'(1);
        else if (pop_en && !push_en) level_d = level_q - LW'(1);
    end

    // rd_data is the registered head; it keeps the last head once the FIFO drains.
    always_comb begin
        rd_data_d = rd_data_q;
        if (pop_en) begin
            if (level_q > LW'(1))   rd_data_d = mem_q[rd_ptr_q + PW'(1)];
            else if (push_en)       rd_data_d = s_q;
        end else if (level_q == '0 && push_en) begin
            rd_data_d = s_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_q       <= DATA_WIDTH'(1);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            s_q       <= s_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_en) mem_q[wr_ptr_q] <= s_q;
    end

`ifdef PRNG_ZERO_SEED_GUARD_EN
    logic seed_err_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)                         seed_err_q <= 1'b0;
        else if (seed_we && seed_data == '0)  seed_err_q <= 1'b1;
    end

    assign seed_err = seed_err_q;
`else
    assign seed_err = 1'b0;
`endif

    assign rd_data    = rd_data_q;
    assign rd_valid   = (level_q != '0);
    assign fifo_level = level_q;

endmodule

// File: tb/tb_prng_lfsr_core.sv
// Bench for prng_lfsr_core: directed scenarios plus random traffic against a queue-based model.
// Honours PRNG_ZERO_SEED_GUARD_EN the same way the design does.
module tb_prng_lfsr_core;

    localparam int          DEPTH = 4;
    localparam logic [31:0] TAPS  = 32'h80200003;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] seed_data = '0;
    logic        seed_we = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  burst_len = '0;
    logic        burst_start = 1'b0;
    logic        rd_pop = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        seed_err;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [31:0] m_s;
    logic [31:0] m_q[$];
    logic [31:0] m_last;
    bit          m_free, m_burst, m_err;
    int          m_rem;

    prng_lfsr_core dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .seed_data(seed_data), .seed_we(seed_we),
        .enable(enable), .burst_len(burst_len), .burst_start(burst_start),
        .rd_pop(rd_pop), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_level(fifo_level), .busy(busy), .seed_err(seed_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ ((s % 2 == 1) ? TAPS : 32'd0);
    endfunction

    task automatic model_reset();
        m_s = 32'd1;
        m_q.delete();
        m_last = '0;
        m_free = 0; m_burst = 0; m_err = 0; m_rem = 0;
    endtask

    task automatic model_edge();
        bit pop, push;
        pop  = rd_pop && (m_q.size() > 0);
        push = (m_free || m_burst) && !seed_we && (m_q.size() < DEPTH || rd_pop);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(m_s);
            m_s = lfsr_next(m_s);
        end
        if (seed_we) begin
`ifdef PRNG_ZERO_SEED_GUARD_EN
            if (seed_data == 0) begin m_s = 32'd1; m_err = 1; end
            else m_s = seed_data;
`else
            m_s = seed_data;
`endif
        end else if (!m_free && !m_burst) begin
            if (enable) m_free = 1;
            else if (burst_start) begin
                m_burst = 1;
                m_rem = (burst_len == 0) ? 256 : int'(burst_len);
            end
        end else if (m_free) begin
            if (!enable) m_free = 0;
        end else if (push) begin
            m_rem--;
            if (m_rem == 0) m_burst = 0;
        end
        if (m_q.size() > 0) m_last = m_q[0];
    endtask

    task automatic check_all();
        chk("rd_valid", rd_valid, m_q.size() != 0);
        chk("fifo_level", fifo_level, m_q.size());
        chk("busy", busy, m_free || m_burst);
        chk("rd_data", rd_data, m_last);
        chk("seed_err", seed_err, m_err);
    endtask

    task automatic tick();
        @(posedge ACLK);
        model_edge();
        @(negedge ACLK);
        check_all();
    endtask

    task automatic drain();
        enable = 0; burst_start = 0; seed_we = 0; rd_pop = 1;
        repeat (DEPTH + 3) tick();
        rd_pop = 0;
    endtask

    logic [31:0] exp1 [4];
    logic [31:0] zero_word;
    bit          zero_err;

    initial begin
        exp1[0] = 32'h00000001; exp1[1] = 32'h80200003;
        exp1[2] = 32'hC0300002; exp1[3] = 32'h60180001;
`ifdef PRNG_ZERO_SEED_GUARD_EN
        zero_word = 32'h1; zero_err = 1;
`else
        zero_word = 32'h0; zero_err = 0;
`endif
        model_reset();
        repeat (3) @(negedge ACLK);
        check_all();
        chk("reset_rd_data", rd_data, 32'h0);
        ARESETN = 1;

        // seeded burst of 4, then pop out
        seed_data = 32'h1; seed_we = 1; tick(); seed_we = 0;
        burst_len = 8'd4; burst_start = 1; tick(); burst_start = 0;
        repeat (5) tick();
        chk("burst_busy_done", busy, 1'b0);
        chk("burst_level", fifo_level, 3'd4);
        for (int i = 0; i < 4; i++) begin
            chk("burst_word", rd_data, exp1[i]);
            rd_pop = 1; tick();
        end
        rd_pop = 0;
        chk("burst_drained", rd_valid, 1'b0);

        // free run with no pops fills and holds, then single pop refills
        enable = 1;
        repeat (6) tick();
        chk("free_full", fifo_level, 3'd4);
        rd_pop = 1; tick(); rd_pop = 0;
        repeat (2) tick();
        chk("free_refill", fifo_level, 3'd4);

        // full FIFO with continuous pops keeps level at 4
        rd_pop = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("stream_level", fifo_level, 3'd4);
        end
        drain();

        // seed during a burst stalls that cycle and keeps the count
        burst_len = 8'd3; burst_start = 1; tick(); burst_start = 0;
        tick();
        seed_data = 32'h12345678; seed_we = 1; tick(); seed_we = 0;
        repeat (4) tick();
        chk("seedburst_level", fifo_level, 3'd3);
        chk("seedburst_busy", busy, 1'b0);
        rd_pop = 1; tick(); rd_pop = 0;
        chk("seedburst_w2", rd_data, 32'h12345678);
        rd_pop = 1; tick(); rd_pop = 0;
        chk("seedburst_w3", rd_data, 32'h091A2B3C);
        drain();

        // zero seed
        seed_data = 32'h0; seed_we = 1; tick(); seed_we = 0;
        enable = 1; repeat (3) tick();
        chk("zero_first", rd_data, zero_word);
        chk("zero_err", seed_err, zero_err);
        drain();
        seed_data = 32'hACE1_0001; seed_we = 1; tick(); seed_we = 0;

        // async reset mid-burst with 3 words buffered
        burst_len = 8'd8; burst_start = 1; tick(); burst_start = 0;
        repeat (3) tick();
        chk("pre_reset_level", fifo_level, 3'd3);
        #2 ARESETN = 0;
        #1;
        model_reset();
        check_all();
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge ACLK);
        ARESETN = 1;
        enable = 1; tick(); tick();
        chk("post_reset_word", rd_data, 32'h1);
        drain();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 6) enable = ~enable;
            burst_start = ($urandom_range(0, 99) < 8);
            burst_len   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            rd_pop      = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 45 : 80));
            seed_we     = ($urandom_range(0, 99) < 3);
            if (seed_we) begin
                seed_data   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                burst_start = 0;
                if (m_free) enable = 1;
                else if (!m_burst) enable = 0;
            end
            tick();
        end
        seed_we = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prng_lfsr_core.md
# prng_lfsr_core

Pseudo-random word generator behind the AXI4-Lite register file of the `axi_prng` IP. It holds a Galois LFSR that register writes seed and step, and buffers generated words in a small FIFO that register reads drain. It is the datapath stage directly downstream of the AXI4-Lite slave's register decode and upstream of its read-data mux.

## Interface

Parameters:
- `DATA_WIDTH`, 32: LFSR and word width.
- `TAPS`, 32'h80200003: Galois feedback mask.
- `FIFO_DEPTH`, 4: output FIFO entries. Must be a power of two, 2..16.

Ports:
- `ACLK`, in, 1: single clock. All logic is rising-edge.
- `ARESETN`, in, 1: asynchronous, active-low reset.
- `seed_data`, in, DATA_WIDTH: seed value.
- `seed_we`, in, 1: one-cycle strobe that loads the seed.
- `enable`, in, 1: level input that requests free-run generation.
- `burst_len`, in, 8: number of words in a burst. 0 means 256.
- `burst_start`, in, 1: one-cycle strobe that starts a burst.
- `rd_pop`, in, 1: one-cycle strobe that pops the FIFO head.
- `rd_data`, out, DATA_WIDTH: FIFO head.
- `rd_valid`, out, 1: FIFO not empty.
- `fifo_level`, out, clog2(FIFO_DEPTH)+1: occupancy.
- `busy`, out, 1: FSM is in FREE or BURST.
- `seed_err`, out, 1: sticky flag for a zero-seed attempt.

## Operation

- **LFSR step:** `next = (s >> 1) ^ (s[0] ? TAPS : 0)`. Each push writes the current `s` into the FIFO, then `s` becomes `next`.
- **FSM states:**
  - IDLE: no generation.
  - FREE: pushes one word per cycle when there is room.
  - BURST: pushes until the remaining count reaches 0.
- **Transitions:**
  - IDLE→FREE when `enable`=1.
  - IDLE→BURST when `burst_start`=1 and `enable`=0. This loads `cnt` = `burst_len` (0 loads 256).
  - FREE→IDLE when `enable`=0.
  - BURST→IDLE on the push that makes `cnt` 0.
  - A `burst_start` outside IDLE is ignored.
  - In BURST, `enable` is ignored until the return to IDLE.
- **Push condition:** state is FREE or BURST, `seed_we`=0, and (`fifo_level` < `FIFO_DEPTH` or `rd_pop`=1).
- **Full FIFO:** no push; the state and `cnt` hold. This is a stall and does not end the burst.
- **Pop:** `rd_pop` with `rd_valid`=1 removes the head. A pop on an empty FIFO is ignored, with no underflow.
- **Pop and push in the same cycle:** both occur. The level is unchanged, including when the FIFO is full.
- **`seed_we`:**
  - Loads `s` and takes priority over a push in the same cycle. No push and no `cnt` decrement occur that cycle.
  - The FSM state is unchanged.
  - The FIFO is not flushed, so stale words remain.
- **Zero seed:** handling depends on `PRNG_ZERO_SEED_GUARD_EN`; see Configuration.

## Timing

- **Reset values:** `s` = 1, FSM = IDLE, FIFO empty, `rd_data` = 0, `rd_valid` = 0, `fifo_level` = 0, `busy` = 0, `seed_err` = 0, `cnt` = 0.
- **Reset mid-operation:** asynchronous. It drops all FIFO contents and any burst immediately.
- **`seed_we` at edge t:** the new `s` is visible at t+1. The first word from that seed is pushed at t+1 if the push condition holds.
- **`enable` sampled 1 at edge t (in IDLE):** `busy` rises after t, the first push happens at t+1, and `rd_valid` rises after t+1.
- **Push at edge t:** `rd_data`/`rd_valid` update after edge t (one-cycle write-to-read latency).
- **Steady state:** a push each cycle while there is room. With `rd_pop` held at 1 every cycle, throughput is 1 word/cycle.
- **Burst end:** `busy` falls after the edge of the final push.
- **`rd_data` after a pop:** shows the new head from the next cycle. It holds its last value when the FIFO is empty.

## Configuration

- **`PRNG_ZERO_SEED_GUARD_EN` defined:**
  - `seed_we` with `seed_data`=0 loads `s` = 1 instead of 0.
  - `seed_err` is set and stays set until reset.
- **`PRNG_ZERO_SEED_GUARD_EN` not defined:**
  - A zero seed is loaded as-is, so the LFSR stays locked at 0 and every pushed word is 0.
  - `seed_err` is tied to 0.

## Test plan

1. Seed 32'h00000001, burst `burst_len`=4, then pop 4 times → words 0x00000001, 0x80200003, 0xC0300002, 0x60180001. `busy` low after the 4th push; `rd_valid`=0 after the 4th pop.
2. `enable`=1 with no pops → `fifo_level` reaches 4 after 4 cycles and holds. Popping one word → exactly one more push, in the pop cycle. The sequence continues without a skipped value.
3. Full FIFO with `rd_pop`=1 each cycle in FREE → `fifo_level` stays 4 and one word per cycle is delivered in LFSR order.
4. In BURST, `seed_we` with 32'h12345678 in the same cycle as a push → no push that cycle and `cnt` unchanged. The next pushed word is 0x12345678 and the burst still yields `burst_len` words in total.
5. Seed 0 with the guard macro defined → `seed_err`=1 and the first word is 0x00000001. Without the macro → all words are 0 and `seed_err`=0.
6. `ARESETN` low mid-burst with 3 words buffered → immediately `rd_valid`=0, `busy`=0, `fifo_level`=0. After release, `enable` → first word 0x00000001.
